ahb_periph_bridge: RTL and testbench

//  AHB-Lite slave that acts as the initiator of the simple peripheral register bus
//  (addrIn/addrOut/sizeDecode/dataIn/dataOut) used by GPIO and similar register blocks.

---
 rtl/ahb_periph_bridge.sv | 112 +++++++++++
 tb/tb_ahb_periph_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_periph_bridge.sv
// rtl/ahb_periph_bridge.sv - AHB-Lite slave driving a simple peripheral register bus
// Writes finish with zero wait states, reads take one wait state, and bad accesses get a two-cycle ERROR response.
module ahb_periph_bridge #(
    parameter int ADDR_W  = 8,
    parameter int REG_NUM = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic [ADDR_W-1:0] addrIn,
    output logic [ADDR_W-1:0] addrOut,
    output logic [3:0]        sizeDecode,
    output logic [31:0]       dataIn,
    input  logic [31:0]       dataOut
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_RD_DONE = 3'd3;
    localparam logic [2:0] S_ERR1    = 3'd4;
    localparam logic [2:0] S_ERR2    = 3'd5;

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(REG_NUM);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [3:0]        r_lanes;
    logic [ADDR_W-1:0] r_addr_in;
    logic [ADDR_W-1:0] r_addr_out;

    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_lanes;
    logic              w_err;
    logic              w_accept;
    logic              w_ready_out;

    assign w_idx = HADDR[ADDR_W+1:2];

    always_comb begin
        w_lanes = 4'b0000;
        case (HSIZE)
            3'd0:    w_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_lanes = 4'b1111;
            default: w_lanes = 4'b0000;
        endcase
    end

    assign w_err = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                 | ({1'b0, w_idx} >= REG_LIMIT);

    assign w_ready_out = (r_state != S_RD_WAIT) && (r_state != S_ERR1);

    // Sampling is also gated on our own ready so that a stalled data phase never accepts a new address.
    assign w_accept = HSEL & HTRANS[1] & HREADY & w_ready_out;

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_accept) begin
            if (w_err)       w_state_nxt = S_ERR1;
            else if (HWRITE) w_state_nxt = S_WR;
            else             w_state_nxt = S_RD_WAIT;
        end else begin
            case (r_state)
                S_RD_WAIT: w_state_nxt = S_RD_DONE;
                S_ERR1:    w_state_nxt = S_ERR2;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_lanes    <= 4'b0000;
            r_addr_in  <= '0;
            r_addr_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_err) begin
                if (HWRITE) begin
                    r_lanes   <= w_lanes;
                    r_addr_in <= w_idx;
                end else begin
                    // Registered here so the peripheral's data lands for RD_DONE, and sees a same-edge write.
                    r_addr_out <= w_idx;
                end
            end
        end
    end

    assign HREADYOUT  = w_ready_out;
    assign HRESP      = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign HRDATA     = (r_state == S_RD_DONE) ? dataOut : 32'h0;
    assign sizeDecode = (r_state == S_WR) ? r_lanes : 4'b0000;
    assign dataIn     = HWDATA;
    assign addrIn     = r_addr_in;
    assign addrOut    = r_addr_out;

endmodule

// File: tb/tb_ahb_periph_bridge.sv
// tb/tb_ahb_periph_bridge.sv - self-checking bench for ahb_periph_bridge
// A registered peripheral model sits behind the bridge, and expected read data comes from a reference memory.
module tb_ahb_periph_bridge;

    logic        clk;
    logic        rstn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [7:0]  addrIn;
    logic [7:0]  addrOut;
    logic [3:0]  sizeDecode;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] pmem    [0:255];
    logic [31:0] ref_mem [0:15];
    logic [31:0] exp_q   [$];

    ahb_periph_bridge #(.ADDR_W(8), .REG_NUM(12)) dut (
        .clk(clk), .rstn(rstn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .addrIn(addrIn), .addrOut(addrOut), .sizeDecode(sizeDecode),
        .dataIn(dataIn), .dataOut(dataOut)
    );

    assign HREADY = HREADYOUT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (sizeDecode[b]) pmem[addrIn][8*b +: 8] <= dataIn[8*b +: 8];
        dataOut <= pmem[addrOut];
    end

    task automatic set_addr(input logic [31:0] a, input logic [2:0] sz, input logic wr);
        HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HSIZE = sz; HWRITE = wr;
    endtask

    task automatic set_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HSIZE = 3'd0; HWRITE = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_idle();
        HWDATA = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b exp 1", HREADYOUT); end
        checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp got %b exp 0", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h exp 0", HRDATA); end
        checks++; if (sizeDecode !== 4'h0) begin errors++; $display("FAIL reset_sizedecode got %b exp 0000", sizeDecode); end
        checks++; if (addrIn !== 8'h0 || addrOut !== 8'h0) begin errors++; $display("FAIL reset_addr got %h/%h exp 0/0", addrIn, addrOut); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_word();
        set_addr(32'h08, 3'd2, 1'b1);
        @(posedge clk); #1;
        set_idle();
        HWDATA = 32'h12345678;
        ref_mem[2] = 32'h12345678;
        @(negedge clk);
        checks++; if (addrIn !== 8'd2) begin errors++; $display("FAIL wword_addrin got %0d exp 2", addrIn); end
        checks++; if (sizeDecode !== 4'b1111) begin errors++; $display("FAIL wword_strobe got %b exp 1111", sizeDecode); end
        checks++; if (dataIn !== 32'h12345678) begin errors++; $display("FAIL wword_datain got %h exp 12345678", dataIn); end
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL wword_resp got %b/%b exp 1/0", HREADYOUT, HRESP); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (sizeDecode !== 4'b0000) begin errors++; $display("FAIL wword_strobe_off got %b exp 0000", sizeDecode); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_half();
        set_addr(32'h0B, 3'd0, 1'b1);
        @(posedge clk); #1;
        HWDATA = 32'hDEADBEEF;
        ref_mem[2][31:24] = 8'hDE;
        set_addr(32'h06, 3'd1, 1'b1);
        @(negedge clk);
        checks++; if (sizeDecode !== 4'b1000) begin errors++; $display("FAIL byte_strobe got %b exp 1000", sizeDecode); end
        checks++; if (addrIn !== 8'd2) begin errors++; $display("FAIL byte_addrin got %0d exp 2", addrIn); end
        @(posedge clk); #1;
        HWDATA = 32'hCAFEF00D;
        ref_mem[1][31:16] = 16'hCAFE;
        set_idle();
        @(negedge clk);
        checks++; if (sizeDecode !== 4'b1100) begin errors++; $display("FAIL half_strobe got %b exp 1100", sizeDecode); end
        checks++; if (addrIn !== 8'd1) begin errors++; $display("FAIL half_addrin got %0d exp 1", addrIn); end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        logic [31:0] addrs [3];
        addrs[0] = 32'h04; addrs[1] = 32'h08; addrs[2] = 32'h2C;
        for (int k = 0; k < 3; k++) begin
            int waits;
            bit got;
            logic [31:0] exp;
            set_addr(addrs[k], 3'd2, 1'b0);
            exp_q.push_back(ref_mem[addrs[k][5:2]]);
            @(posedge clk); #1;
            set_idle();
            waits = 0; got = 0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (HREADYOUT === 1'b1) begin got = 1; break; end
                waits++;
            end
            exp = exp_q.pop_front();
            checks++; if (!got || waits != 1) begin errors++; $display("FAIL read_latency[%0d] got %0d waits exp 1", k, waits); end
            checks++; if (HRDATA !== exp) begin errors++; $display("FAIL read_data[%0d] got %h exp %h", k, HRDATA, exp); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL read_hrdata_idle got %h exp 0", HRDATA); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int waits;
        bit got;
        logic [31:0] exp;
        set_addr(32'h0C, 3'd2, 1'b1);
        @(posedge clk); #1;
        HWDATA = 32'hA5A5A5A5;
        ref_mem[3] = 32'hA5A5A5A5;
        set_addr(32'h0C, 3'd2, 1'b0);
        exp_q.push_back(ref_mem[3]);
        @(posedge clk); #1;
        set_idle();
        waits = 0; got = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (HREADYOUT === 1'b1) begin got = 1; break; end
            waits++;
        end
        exp = exp_q.pop_front();
        checks++; if (!got || waits != 1) begin errors++; $display("FAIL raw_latency got %0d waits exp 1", waits); end
        checks++; if (HRDATA !== exp) begin errors++; $display("FAIL raw_data got %h exp %h", HRDATA, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] ea [4];
        logic [2:0]  es [4];
        logic        ew [4];
        ea[0] = 32'h01; es[0] = 3'd1; ew[0] = 1'b1;
        ea[1] = 32'h02; es[1] = 3'd2; ew[1] = 1'b0;
        ea[2] = 32'h30; es[2] = 3'd2; ew[2] = 1'b0;
        ea[3] = 32'h00; es[3] = 3'd3; ew[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_addr(ea[k], es[k], ew[k]);
            @(posedge clk); #1;
            set_idle();
            HWDATA = 32'hFFFFFFFF;
            @(negedge clk);
            checks++; if (HREADYOUT !== 1'b0 || HRESP !== 1'b1 || sizeDecode !== 4'b0)
                begin errors++; $display("FAIL err1[%0d] got rdy=%b resp=%b strb=%b exp 0/1/0000", k, HREADYOUT, HRESP, sizeDecode); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b1 || sizeDecode !== 4'b0)
                begin errors++; $display("FAIL err2[%0d] got rdy=%b resp=%b strb=%b exp 1/1/0000", k, HREADYOUT, HRESP, sizeDecode); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL err_end[%0d] got %b exp 0", k, HRESP); end
            @(posedge clk); #1;
        end
        begin
            int waits;
            bit got;
            logic [31:0] exp;
            set_addr(32'h00, 3'd2, 1'b0);
            exp_q.push_back(ref_mem[0]);
            @(posedge clk); #1;
            set_idle();
            waits = 0; got = 0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (HREADYOUT === 1'b1) begin got = 1; break; end
                waits++;
            end
            exp = exp_q.pop_front();
            checks++; if (!got || HRDATA !== exp) begin errors++; $display("FAIL err_nowrite got %h exp %h", HRDATA, exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int waits;
        bit got;
        logic [31:0] exp;
        set_addr(32'h04, 3'd2, 1'b0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        checks++; if (HREADYOUT !== 1'b0) begin errors++; $display("FAIL mid_rdwait got %b exp 0", HREADYOUT); end
        rstn = 1'b0;
        #1;
        checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL mid_reset_resp got %b/%b exp 1/0", HREADYOUT, HRESP); end
        checks++; if (sizeDecode !== 4'b0 || addrOut !== 8'h0 || HRDATA !== 32'h0)
            begin errors++; $display("FAIL mid_reset_out got strb=%b aout=%h rd=%h exp 0/0/0", sizeDecode, addrOut, HRDATA); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        set_addr(32'h0C, 3'd2, 1'b0);
        exp_q.push_back(ref_mem[3]);
        @(posedge clk); #1;
        set_idle();
        waits = 0; got = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (HREADYOUT === 1'b1) begin got = 1; break; end
            waits++;
        end
        exp = exp_q.pop_front();
        checks++; if (!got || waits != 1) begin errors++; $display("FAIL post_reset_latency got %0d waits exp 1", waits); end
        checks++; if (HRDATA !== exp) begin errors++; $display("FAIL post_reset_data got %h exp %h", HRDATA, exp); end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pmem[i] = 32'h01010101 * (i % 16) + 32'h10000000;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h01010101 * i + 32'h10000000;
        test_reset();
        test_write_word();
        test_byte_half();
        test_read();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
